// File: rtl/cswap_serial_adder.sv
// Bit-serial W-bit adder around one Fredkin-gate full adder, with valid/ready on both sides.
// Optional signed-overflow output ovf_out is built when CSWAP_SADD_OVF_EN is defined.

module cswap_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Each stage is a controlled swap; only the routed output of each gate is kept.
    assign p    = a ? ~b : b;
    assign cout = p ? cin : a;
    assign s    = p ? ~cin : cin;

endmodule

module cswap_serial_adder #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum_out,
    output logic         cout_out
`ifdef CSWAP_SADD_OVF_EN
    ,
    output logic         ovf_out
`endif
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fa_s, fa_cout;

    cswap_fa u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = cin_in;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d  = {1'b0, a_sh_q[W-1:1]};
                b_sh_d  = {1'b0, b_sh_q[W-1:1]};
                res_d   = {fa_s, res_q[W-1:1]};
                carry_d = fa_cout;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum_out  = res_q;
    assign cout_out = carry_q;

`ifdef CSWAP_SADD_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is carry_q during the last RUN cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StRun && cnt_q == CntLast) begin
            ovf_d = carry_q ^ fa_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_out = (state_q == StDone) & ovf_q;
`endif

endmodule

// File: tb/tb_cswap_serial_adder.sv
// Directed-vector and random bench for cswap_serial_adder at W=8.
// Overflow expectations are checked when CSWAP_SADD_OVF_EN is defined.

module tb_cswap_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;

    int checks;
    int failures;

    cswap_serial_adder #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout_out  (cout_out)
`ifdef CSWAP_SADD_OVF_EN
        ,
        .ovf_out   (ovf_out)
`endif
    );

`ifndef CSWAP_SADD_OVF_EN
    assign ovf_out = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, wait for out_valid, stall stall_n cycles, then hand off.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int stall_n, input logic chk_stall,
                          output logic [W-1:0] s, output logic c, output logic o,
                          output int lat);
        int n;
        n = 0;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        cin_in = cin;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'(n), 0);
        tick();
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        cin_in = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        s = sum_out;
        c = cout_out;
        o = ovf_out;
        for (int i = 0; i < stall_n; i++) begin
            tick();
            if (chk_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_sum", 32'(sum_out), 32'(s));
                check("stall_cout", 32'(cout_out), 32'(c));
                check("stall_in_ready", 32'(in_ready), 0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    vec_t vecs[10];
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           lat;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic         exp_ovf;
    int           seen_valid;
    int           n;

    initial begin
        checks = 0;
        failures = 0;
        vecs[0] = '{8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[9] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        cin_in = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum_out), 0);
        check("rst_cout", 32'(cout_out), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, 1'b0, s, c, o, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), W);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
`ifdef CSWAP_SADD_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
`endif
            check($sformatf("vec%0d_idle_ready", i), 32'(in_ready), 1);
            check($sformatf("vec%0d_idle_valid", i), 32'(out_valid), 0);
        end

        // Reset three cycles into RUN: result discarded.
        in_valid = 1'b1;
        a_in = 8'h0F;
        b_in = 8'h01;
        cin_in = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrun_rst_sum", 32'(sum_out), 0);
        check("midrun_rst_cout", 32'(cout_out), 0);
        check("midrun_rst_valid", 32'(out_valid), 0);
        check("midrun_rst_ready", 32'(in_ready), 1);
        check("midrun_rst_ovf", 32'(ovf_out), 0);
        tick();
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        check("midrun_no_valid", 32'(seen_valid), 0);

        // Backpressure with checks on held outputs.
        run_op(8'h3C, 8'h41, 1'b0, 5, 1'b1, s, c, o, lat);
        check("bp_sum", 32'(s), 32'h7D);
        check("bp_cout", 32'(c), 0);

        // in_valid pulsed during RUN and held through DONE must not be taken early.
        in_valid = 1'b1;
        a_in = 8'h12;
        b_in = 8'h34;
        cin_in = 1'b1;
        tick();
        a_in = 8'hEE;
        b_in = 8'hEE;
        cin_in = 1'b0;
        tick();
        tick();
        check("run_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("pulse_sum", 32'(sum_out), 32'h47);
        check("pulse_cout", 32'(cout_out), 0);
        repeat (3) begin
            tick();
            check("done_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_hs_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("second_sum", 32'(sum_out), 32'hDC);
        check("second_cout", 32'(cout_out), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            exp_ovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'b0, s, c, o, lat);
            check("rnd_sum", 32'({c, s}), 32'(full));
            check("rnd_latency", 32'(lat), W);
`ifdef CSWAP_SADD_OVF_EN
            check("rnd_ovf", 32'(o), 32'(exp_ovf));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
